event_edge_capture: RTL and testbench

Event-list producer: watches `N_CH` synchronous inputs and detects a per-channel-selected edge type (posedge, negedge, any edge, or none). All channels firing in the same cycle merge into one OR-combined event record. Records are buffered in a small FIFO and delivered over a valid/ready stream. It is the generating end of the event-control semantics that the lint rules check: where a waiter blocks on `@(posedge a, negedge b, edge c)`, this block reports which of those events occurred and when.

---
 rtl/event_capture_pkg.sv | 25 ++
 rtl/event_capture_fifo.sv | 50 +++++
 rtl/event_edge_capture.sv | 124 ++++++++++++
 tb/tb_event_edge_capture.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/event_capture_pkg.sv
// Shared types and helpers for the event edge capture block.
// Holds the per-channel edge-mode encoding, the drop counter width,
// and the single-channel edge detection function.
package event_capture_pkg;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        POSEDGE = 2'd1,
        NEGEDGE = 2'd2,
        EDGE    = 2'd3
    } edge_mode_e;

    localparam int DROP_CNT_W = 8;

    // Returns whether one channel fires, given its mode, current sample and previous sample.
    function automatic logic edge_hit(edge_mode_e mode, logic s, logic p);
        case (mode)
            POSEDGE: return s & ~p;
            NEGEDGE: return ~s & p;
            EDGE:    return s ^ p;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/event_capture_fifo.sv
// Synchronous FIFO holding event records.
// Pointers carry one extra wrap bit so full and empty can be told apart.
// A push into a full FIFO is still accepted when a pop happens in the same
// cycle, because the slot being written is the one being freed.
// There is no bypass: a record pushed into an empty FIFO is visible next cycle.
module event_capture_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop);
    assign head_data = mem[rd_ptr[AW-1:0]];

    // Advance read and write pointers; reset empties the FIFO at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Store accepted records; storage needs no reset since empty gates its use.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/event_edge_capture.sv
// Event-list producer: detects per-channel edges on synchronous inputs,
// merges all channels firing in one cycle into a single record, buffers
// records in a FIFO and delivers them over a valid/ready stream.
// Optional feature macro: EVENT_CAPTURE_TIMESTAMP_EN adds a free-running
// timestamp to every record; without it evt_ts_o is tied to 0.
module event_edge_capture
    import event_capture_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int DEPTH = 8,
    parameter int TS_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       sig_i,
    input  logic [2*N_CH-1:0]     mode_i,
    input  logic                  clear_i,
    output logic                  evt_valid_o,
    input  logic                  evt_ready_i,
    output logic [N_CH-1:0]       evt_mask_o,
    output logic [TS_W-1:0]       evt_ts_o,
    output logic                  ovf_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);

`ifdef EVENT_CAPTURE_TIMESTAMP_EN
    localparam int ENTRY_W = N_CH + TS_W;
`else
    localparam int ENTRY_W = N_CH;
`endif

    logic [N_CH-1:0]       s_q;
    logic [N_CH-1:0]       p_q;
    logic                  primed_q;
    logic [N_CH-1:0]       hit;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  full;
    logic                  empty;
    logic [ENTRY_W-1:0]    entry;
    logic [ENTRY_W-1:0]    head_data;
    logic                  ovf_q;
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    // Sample inputs; while priming both registers take the same sample so a
    // signal already high at reset release cannot look like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q      <= '0;
            p_q      <= '0;
            primed_q <= 1'b0;
        end else begin
            s_q      <= sig_i;
            p_q      <= primed_q ? s_q : sig_i;
            primed_q <= 1'b1;
        end
    end

    // Per-channel edge detection using the mode presented in this cycle.
    always_comb begin
        hit = '0;
        if (primed_q) begin
            for (int c = 0; c < N_CH; c++) begin
                hit[c] = edge_hit(edge_mode_e'(mode_i[2*c +: 2]), s_q[c], p_q[c]);
            end
        end
    end

`ifdef EVENT_CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    // Free-running timestamp; wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ts_q <= '0;
        else     ts_q <= ts_q + TS_W'(1);
    end

    assign entry    = {hit, ts_q};
    assign evt_ts_o = evt_valid_o ? head_data[TS_W-1:0] : '0;
`else
    assign entry    = hit;
    assign evt_ts_o = '0;
`endif

    assign push        = |hit;
    assign evt_valid_o = ~empty;
    assign pop         = evt_valid_o & evt_ready_i;
    assign drop        = push & full & ~pop;
    assign evt_mask_o  = evt_valid_o ? head_data[ENTRY_W-1 -: N_CH] : '0;

    event_capture_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (entry),
        .pop       (pop),
        .head_data (head_data),
        .full      (full),
        .empty     (empty)
    );

    // Overflow tracking; a drop in the same cycle as clear still counts as one drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            ovf_q <= 1'b1;
            if (clear_i)               drop_cnt_q <= DROP_CNT_W'(1);
            else if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
        end else if (clear_i) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end
    end

    assign ovf_o      = ovf_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_event_edge_capture.sv
// Directed testbench for event_edge_capture with N_CH=4, DEPTH=8, TS_W=4.
// Expected timestamps follow the build: real values with
// EVENT_CAPTURE_TIMESTAMP_EN, zero otherwise.
module tb_event_edge_capture;

    logic       clk;
    logic       rst;
    logic [3:0] sig_i;
    logic [7:0] mode_i;
    logic       clear_i;
    logic       evt_valid_o;
    logic       evt_ready_i;
    logic [3:0] evt_mask_o;
    logic [3:0] evt_ts_o;
    logic       ovf_o;
    logic [7:0] drop_cnt_o;

    int         check_cnt;
    int         pass_cnt;
    logic [3:0] ts_model;
    logic [3:0] s;
    logic [3:0] t;
    logic [7:0] exp_q[$];
    logic [7:0] e;

    event_edge_capture #(
        .N_CH  (4),
        .DEPTH (8),
        .TS_W  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sig_i       (sig_i),
        .mode_i      (mode_i),
        .clear_i     (clear_i),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (evt_ready_i),
        .evt_mask_o  (evt_mask_o),
        .evt_ts_o    (evt_ts_o),
        .ovf_o       (ovf_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference timestamp: edges counted since reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) ts_model <= 4'd0;
        else     ts_model <= ts_model + 4'd1;
    end

    function automatic logic [3:0] expTs(input logic [3:0] v);
`ifdef EVENT_CAPTURE_TIMESTAMP_EN
        return v;
`else
        return 4'd0 & v;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_cnt++;
        if (observed === expected) pass_cnt++;
        else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    endtask

    // Drive inputs at a falling edge and return at the next falling edge.
    task automatic applyStimulus(input logic [3:0] sig, input logic [7:0] mode,
                                 input logic ready, input logic clr);
        sig_i       = sig;
        mode_i      = mode;
        evt_ready_i = ready;
        clear_i     = clr;
        @(negedge clk);
    endtask

    task automatic drainQueue(input string tag);
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            checkOutput({tag, " valid"}, evt_valid_o, 1'b1);
            checkOutput({tag, " mask"}, evt_mask_o, e[7:4]);
            checkOutput({tag, " ts"}, evt_ts_o, expTs(e[3:0]));
            applyStimulus(s, 8'hFF, 1'b1, 1'b0);
        end
        applyStimulus(s, 8'hFF, 1'b0, 1'b0);
        checkOutput({tag, " empty after drain"}, evt_valid_o, 1'b0);
    endtask

    initial begin
        check_cnt   = 0;
        pass_cnt    = 0;
        rst         = 1'b1;
        sig_i       = 4'b1111;
        mode_i      = 8'hFF;
        evt_ready_i = 1'b0;
        clear_i     = 1'b0;
        s           = 4'b1111;
        repeat (3) @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rst valid", evt_valid_o, 1'b0);
        checkOutput("rst mask", evt_mask_o, 4'h0);
        checkOutput("rst ts", evt_ts_o, 4'h0);
        checkOutput("rst ovf", ovf_o, 1'b0);
        checkOutput("rst drop", drop_cnt_o, 8'd0);

        $display("[TB] priming with inputs high");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'b1111, 8'hFF, 1'b0, 1'b0);
            checkOutput("prime no record", evt_valid_o, 1'b0);
        end

        $display("[TB] NONE mode and single posedge");
        repeat (3) applyStimulus(4'b0000, 8'h00, 1'b0, 1'b0);
        checkOutput("none mode", evt_valid_o, 1'b0);
        applyStimulus(4'b0001, 8'h01, 1'b0, 1'b0);
        t = ts_model;
        checkOutput("latency detect cycle", evt_valid_o, 1'b0);
        applyStimulus(4'b0001, 8'h01, 1'b0, 1'b0);
        checkOutput("pos valid", evt_valid_o, 1'b1);
        checkOutput("pos mask", evt_mask_o, 4'b0001);
        checkOutput("pos ts", evt_ts_o, expTs(t));
        applyStimulus(4'b0001, 8'h01, 1'b0, 1'b0);
        checkOutput("pos hold mask", evt_mask_o, 4'b0001);
        applyStimulus(4'b0001, 8'h01, 1'b1, 1'b0);
        checkOutput("pos popped", evt_valid_o, 1'b0);

        $display("[TB] simultaneous negedge and edge");
        repeat (2) applyStimulus(4'b0111, 8'h00, 1'b0, 1'b0);
        applyStimulus(4'b0001, 8'h38, 1'b0, 1'b0);
        t = ts_model;
        applyStimulus(4'b0001, 8'h38, 1'b0, 1'b0);
        checkOutput("merge valid", evt_valid_o, 1'b1);
        checkOutput("merge mask", evt_mask_o, 4'b0110);
        checkOutput("merge ts", evt_ts_o, expTs(t));
        applyStimulus(4'b0001, 8'h38, 1'b1, 1'b0);
        checkOutput("merge single record", evt_valid_o, 1'b0);

        $display("[TB] overflow with ten events");
        s = 4'b0001;
        applyStimulus(s, 8'hFF, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            s = s ^ 4'(i);
            applyStimulus(s, 8'hFF, 1'b0, 1'b0);
            if (i <= 8) exp_q.push_back({4'(i), ts_model});
        end
        applyStimulus(s, 8'hFF, 1'b0, 1'b0);
        checkOutput("ovf valid", evt_valid_o, 1'b1);
        checkOutput("ovf flag", ovf_o, 1'b1);
        checkOutput("ovf drop count", drop_cnt_o, 8'd2);
        s = s ^ 4'hC;
        applyStimulus(s, 8'hFF, 1'b0, 1'b0);
        applyStimulus(s, 8'hFF, 1'b0, 1'b1);
        checkOutput("clear+drop ovf", ovf_o, 1'b1);
        checkOutput("clear+drop count", drop_cnt_o, 8'd1);
        applyStimulus(s, 8'hFF, 1'b0, 1'b1);
        checkOutput("clear ovf", ovf_o, 1'b0);
        checkOutput("clear count", drop_cnt_o, 8'd0);
        applyStimulus(s, 8'hFF, 1'b0, 1'b0);
        drainQueue("ovf drain");

        $display("[TB] push while full with pop");
        for (int i = 1; i <= 8; i++) begin
            s = s ^ 4'(i);
            applyStimulus(s, 8'hFF, 1'b0, 1'b0);
            exp_q.push_back({4'(i), ts_model});
        end
        applyStimulus(s, 8'hFF, 1'b0, 1'b0);
        checkOutput("full no ovf", ovf_o, 1'b0);
        s = s ^ 4'hB;
        applyStimulus(s, 8'hFF, 1'b0, 1'b0);
        t = ts_model;
        applyStimulus(s, 8'hFF, 1'b1, 1'b0);
        void'(exp_q.pop_front());
        exp_q.push_back({4'hB, t});
        checkOutput("full pop drop", drop_cnt_o, 8'd0);
        checkOutput("full pop ovf", ovf_o, 1'b0);
        drainQueue("full pop drain");

        $display("[TB] timestamp wrap");
        for (int i = 0; i < 20 && ts_model != 4'd14; i++) applyStimulus(s, 8'hFF, 1'b0, 1'b0);
        checkOutput("wrap align", ts_model, 4'd14);
        s = s ^ 4'h1;
        applyStimulus(s, 8'hFF, 1'b0, 1'b0);
        s = s ^ 4'h2;
        applyStimulus(s, 8'hFF, 1'b0, 1'b0);
        applyStimulus(s, 8'hFF, 1'b0, 1'b0);
        checkOutput("wrap first mask", evt_mask_o, 4'h1);
        checkOutput("wrap first ts", evt_ts_o, expTs(4'hF));
        applyStimulus(s, 8'hFF, 1'b1, 1'b0);
        checkOutput("wrap second mask", evt_mask_o, 4'h2);
        checkOutput("wrap second ts", evt_ts_o, expTs(4'h0));
        applyStimulus(s, 8'hFF, 1'b1, 1'b0);
        checkOutput("wrap drained", evt_valid_o, 1'b0);

        $display("[TB] async reset mid-stream");
        s = s ^ 4'h4;
        applyStimulus(s, 8'hFF, 1'b0, 1'b0);
        applyStimulus(s, 8'hFF, 1'b0, 1'b0);
        checkOutput("pre-reset valid", evt_valid_o, 1'b1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async rst valid", evt_valid_o, 1'b0);
        checkOutput("async rst mask", evt_mask_o, 4'h0);
        @(negedge clk);
        s = 4'b1011;
        sig_i = s;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(s, 8'hFF, 1'b0, 1'b0);
        checkOutput("re-prime no record", evt_valid_o, 1'b0);
        s = s ^ 4'h8;
        applyStimulus(s, 8'hFF, 1'b0, 1'b0);
        applyStimulus(s, 8'hFF, 1'b0, 1'b0);
        checkOutput("post-reset valid", evt_valid_o, 1'b1);
        checkOutput("post-reset mask", evt_mask_o, 4'h8);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
